life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
Parametrised Game-of-Life engine with a programmable birth/survive rule, selectable toroidal or dead-edge boundaries, and single-step control. The board is double-buffered, so an update writes the inactive bank and a one-cycle bank swap replaces the copy pass. It sits between the VGA pixel pipeline, which uses the combinational read port, and top-level control pins (run, step, randomize). It also has a host write port for pattern loading and reports generation and population counters.

Parameters:
LOG_W, 6, log2 board width (W = 2**LOG_W)
LOG_H, 5, log2 board height (H = 2**LOG_H)
UPDATE_DIV, 2400000, clk cycles between auto-updates while running
SEED, 16'h0001, LFSR reset seed; 0 is illegal and is treated as 16'h0001

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = auto-update every UPDATE_DIV cycles
step_req  in  1  pulse; one generation when run=0
randomize_req  in  1  level; when high at a trigger, reseed the board instead of updating
wrap_en  in  1  1 = toroidal, 0 = out-of-board neighbours are dead
birth_mask  in  9  bit n = dead cell with n neighbours becomes live
survive_mask  in  9  bit n = live cell with n neighbours stays live
frame_sync  in  1  vsync level; updates start on its rising edge
wr_en  in  1  host write into the active bank; honoured in IDLE only
wr_x  in  LOG_W  write column
wr_y  in  LOG_H  write row
wr_data  in  1  cell value
rd_x  in  LOG_W  display read column
rd_y  in  LOG_H  display read row
rd_cell  out  1  active-bank cell at (rd_x, rd_y); combinational
busy  out  1  1 whenever the state is not IDLE
generation  out  16  generations since the last randomize; wraps at 65535
population  out  LOG_W+LOG_H+1  live-cell count of the active bank

Behaviour:
- Cell index = y*W + x. There are two banks, bank[0] and bank[1]. The active bank is selected by register `act`, which resets to 0.
- States are INIT, IDLE, WAIT_SYNC, UPDATE and SWAP. Async reset forces INIT with act=0, timer=0, generation=0, population=0, LFSR=SEED and an index of 0.
- INIT: exactly W*H cycles, one cell per cycle in index order. Each cycle writes LFSR[0] into the active bank and adds it to a population accumulator. The write is visible on rd_cell immediately. After the last cell: population = accumulator, generation = 0, next state IDLE.
- LFSR: 16-bit, free-running every cycle from reset. Shift left; the new bit[0] = b15^b13^b12^b10.
- IDLE:
  - If run=1, timer increments. When timer == UPDATE_DIV-1, timer clears and the state goes to WAIT_SYNC.
  - If run=0, timer holds and step_req=1 goes to WAIT_SYNC.
  - While run=1, step_req is ignored.
  - wr_en writes wr_data to the active bank at (wr_x, wr_y) and updates population by +1/-1 only when the cell value actually changes.
- WAIT_SYNC: frame_sync is registered. On a detected rising edge (prev=0, cur=1), sample randomize_req, wrap_en, birth_mask and survive_mask into latches. If the latched randomize is 1, go to INIT; otherwise go to UPDATE with index 0. Mask and mode changes during a pass have no effect on that pass.
- UPDATE: exactly W*H cycles, one cell per cycle.
  - n = count of the 8 neighbours (0..8) read from the active bank.
  - With wrap off, any neighbour coordinate outside the board contributes 0. With wrap on, coordinates are taken modulo W and H.
  - next = cur ? survive_mask[n] : birth_mask[n]. next is written to the inactive bank and accumulated into the population accumulator.
  - The active bank is never written during UPDATE.
- SWAP: 1 cycle. act toggles, population is loaded from the accumulator, generation increments, next state IDLE. rd_cell switches banks atomically at the clock edge that leaves SWAP.
- Trigger-to-new-display latency = (cycles until a frame_sync edge) + W*H + 1.
- Reset mid-INIT or mid-UPDATE abandons the pass. The inactive bank contents are don't-care, and the full INIT repeats after reset release.
- busy reads 0 only in IDLE.

Test Plan:
- Reset with LOG_W=3, LOG_H=3: busy=1 for exactly 64 cycles. Board equals a bench LFSR model of the first 64 LSBs from seed 1. population equals their popcount; generation=0.
- Blinker at (3,2),(3,3),(3,4), rule B3/S23 (birth=9'h008, survive=9'h00C), run=0, step_req, frame_sync edge: cells (2,3),(3,3),(4,3) are live, population=3, generation=1. A second step returns the vertical blinker and generation=2.
- Wrap test: cells (0,0),(7,0),(0,7), birth_mask bit 3 only, survive=0. With wrap_en=1, cell (7,7) becomes live; with wrap_en=0 it stays dead and population=0.
- Glider on 8x8, wrap_en=1: after 32 steps the board equals the initial pattern and population=5 at every step.
- run=1, UPDATE_DIV=100, frame_sync pulsing every 300 cycles: exactly one generation per frame_sync edge following each timer expiry. With randomize_req=1 at the edge, INIT runs instead and generation=0.
- Assert wr_en during UPDATE: no bank change. Assert rst_n=0 mid-UPDATE: act=0 and a full INIT follows release.

Source files
------------

// File: rtl/life_engine.sv
// rtl/life_engine.sv - double-buffered Game-of-Life engine with programmable rule
//
// Purpose: holds a W x H board in two banks. A pass computes every cell of the
// next generation from the active bank into the inactive bank, and the banks
// then swap in one cycle. INIT fills the active bank from a free-running LFSR.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   run, step_req               auto-update enable / single-step pulse
//   randomize_req               reseed instead of update at the next trigger
//   wrap_en                     toroidal (1) or dead-edge (0) neighbourhood
//   birth_mask, survive_mask    rule tables indexed by neighbour count
//   frame_sync                  passes start on its rising edge
//   wr_en, wr_x, wr_y, wr_data  host cell write into the active bank (IDLE only)
//   rd_x, rd_y, rd_cell         combinational display read of the active bank
//   busy                        state is not IDLE
//   generation, population      generation counter / live cells in active bank

module life_engine #(
   parameter int          LOG_W      = 6,
   parameter int          LOG_H      = 5,
   parameter int          UPDATE_DIV = 2400000,
   parameter logic [15:0] SEED       = 16'h0001
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   step_req,
   input  logic                   randomize_req,
   input  logic                   wrap_en,
   input  logic [8:0]             birth_mask,
   input  logic [8:0]             survive_mask,
   input  logic                   frame_sync,
   input  logic                   wr_en,
   input  logic [LOG_W-1:0]       wr_x,
   input  logic [LOG_H-1:0]       wr_y,
   input  logic                   wr_data,
   input  logic [LOG_W-1:0]       rd_x,
   input  logic [LOG_H-1:0]       rd_y,
   output logic                   rd_cell,
   output logic                   busy,
   output logic [15:0]            generation,
   output logic [LOG_W+LOG_H:0]   population
);

   localparam int N  = 2**(LOG_W+LOG_H);
   localparam int IW = LOG_W + LOG_H;
   localparam int PW = IW + 1;
   // An all-zero LFSR would lock up, so a zero seed falls back to 1.
   localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [31:0]   DIV_LAST = 32'(UPDATE_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT_SYNC, S_UPDATE, S_SWAP} state_t;

   state_t          state;
   logic            act;
   logic [IW-1:0]   idx;
   logic [31:0]     timer;
   logic [15:0]     gen_q;
   logic [PW-1:0]   pop_q;
   logic [PW-1:0]   acc;
   logic [15:0]     lfsr;
   logic            fs_cur;
   logic            fs_prev;
   logic            wrap_l;
   logic [8:0]      birth_l;
   logic [8:0]      survive_l;

   logic [N-1:0]    bank [2];
   logic [N-1:0]    act_bank;

   logic [LOG_W-1:0] cx, xm, xp;
   logic [LOG_H-1:0] cy, ym, yp;
   logic             x_lo_ok, x_hi_ok, y_lo_ok, y_hi_ok;
   logic [3:0]       nbr_cnt;
   logic             cur_cell;
   logic             next_cell;
   logic [IW-1:0]    wr_idx;

   assign act_bank   = bank[act];
   assign rd_cell    = act_bank[{rd_y, rd_x}];
   assign busy       = (state != S_IDLE);
   assign generation = gen_q;
   assign population = pop_q;
   assign wr_idx     = {wr_y, wr_x};

   // Neighbour coordinates wrap naturally in LOG_W/LOG_H bits; the *_ok flags
   // mask the wrapped neighbours off when the board edge is dead.
   assign cx      = idx[LOG_W-1:0];
   assign cy      = idx[IW-1:LOG_W];
   assign xm      = cx - 1'b1;
   assign xp      = cx + 1'b1;
   assign ym      = cy - 1'b1;
   assign yp      = cy + 1'b1;
   assign x_lo_ok = wrap_l | (cx != '0);
   assign x_hi_ok = wrap_l | (cx != '1);
   assign y_lo_ok = wrap_l | (cy != '0);
   assign y_hi_ok = wrap_l | (cy != '1);

   always_comb begin
      nbr_cnt = 4'd0;
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{ym, xm}] & y_lo_ok & x_lo_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{ym, cx}] & y_lo_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{ym, xp}] & y_lo_ok & x_hi_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{cy, xm}] & x_lo_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{cy, xp}] & x_hi_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{yp, xm}] & y_hi_ok & x_lo_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{yp, cx}] & y_hi_ok};
      nbr_cnt = nbr_cnt + {3'b000, act_bank[{yp, xp}] & y_hi_ok & x_hi_ok};
      cur_cell  = act_bank[idx];
      next_cell = cur_cell ? survive_l[nbr_cnt] : birth_l[nbr_cnt];
   end

   // Board storage carries no reset: its contents are rebuilt by INIT.
   always_ff @(posedge clk) begin
      case (state)
         S_INIT:   bank[act][idx] <= lfsr[0];
         S_UPDATE: bank[~act][idx] <= next_cell;
         S_IDLE:   if (wr_en) bank[act][wr_idx] <= wr_data;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         act       <= 1'b0;
         idx       <= '0;
         timer     <= '0;
         gen_q     <= '0;
         pop_q     <= '0;
         acc       <= '0;
         lfsr      <= SEED_EFF;
         fs_cur    <= 1'b0;
         fs_prev   <= 1'b0;
         wrap_l    <= 1'b0;
         birth_l   <= '0;
         survive_l <= '0;
      end else begin
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         fs_cur  <= frame_sync;
         fs_prev <= fs_cur;
         case (state)
            S_INIT: begin
               acc <= acc + PW'(lfsr[0]);
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  pop_q <= acc + PW'(lfsr[0]);
                  gen_q <= '0;
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (run) begin
                  if (timer == DIV_LAST) begin
                     timer <= '0;
                     state <= S_WAIT_SYNC;
                  end else begin
                     timer <= timer + 32'd1;
                  end
               end else if (step_req) begin
                  state <= S_WAIT_SYNC;
               end
               // Population tracks host writes only when the cell flips.
               if (wr_en && (wr_data != act_bank[wr_idx])) begin
                  pop_q <= wr_data ? pop_q + 1'b1 : pop_q - 1'b1;
               end
            end
            S_WAIT_SYNC: begin
               if (fs_cur && !fs_prev) begin
                  wrap_l    <= wrap_en;
                  birth_l   <= birth_mask;
                  survive_l <= survive_mask;
                  idx       <= '0;
                  acc       <= '0;
                  state     <= randomize_req ? S_INIT : S_UPDATE;
               end
            end
            S_UPDATE: begin
               acc <= acc + PW'(next_cell);
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) state <= S_SWAP;
            end
            S_SWAP: begin
               act   <= ~act;
               pop_q <= acc;
               gen_q <= gen_q + 16'd1;
               state <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - self-checking bench for life_engine on an 8x8 board

module tb_life_engine;

   localparam int W = 8;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        step_req = 1'b0;
   logic        randomize_req = 1'b0;
   logic        wrap_en = 1'b0;
   logic [8:0]  birth_mask = 9'h008;
   logic [8:0]  survive_mask = 9'h00C;
   logic        frame_sync = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_x = '0;
   logic [2:0]  wr_y = '0;
   logic        wr_data = 1'b0;
   logic [2:0]  rd_x = '0;
   logic [2:0]  rd_y = '0;
   logic        rd_cell;
   logic        busy;
   logic [15:0] generation;
   logic [6:0]  population;

   int tests = 0;
   int fails = 0;

   logic [63:0] q_board [$];
   logic [6:0]  q_pop [$];
   logic [15:0] q_gen [$];
   logic [63:0] model;
   logic [15:0] gen_m;

   localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] CORNERS = 64'h0100_0000_0000_0081;
   localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

   life_engine #(.LOG_W(3), .LOG_H(3), .UPDATE_DIV(100), .SEED(16'h0001)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req),
      .randomize_req(randomize_req), .wrap_en(wrap_en),
      .birth_mask(birth_mask), .survive_mask(survive_mask),
      .frame_sync(frame_sync), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
      .busy(busy), .generation(generation), .population(population)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] life_next(input logic [63:0] b, input logic [8:0] bm,
                                             input logic [8:0] sm, input logic w);
      logic [63:0] r;
      r = '0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int n;
            logic [3:0] n4;
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int nx;
                  int ny;
                  nx = x + dx;
                  ny = y + dy;
                  if (dx == 0 && dy == 0) continue;
                  if (w) begin
                     nx = (nx + W) % W;
                     ny = (ny + H) % H;
                  end else if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                     continue;
                  end
                  n = n + int'(b[ny*W+nx]);
               end
            end
            n4 = 4'(n);
            r[y*W+x] = b[y*W+x] ? sm[n4] : bm[n4];
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] popcnt(input logic [63:0] b);
      int c;
      c = 0;
      for (int i = 0; i < 64; i++) c = c + int'(b[i]);
      return 7'(c);
   endfunction

   function automatic logic [63:0] lfsr_board();
      logic [63:0] b;
      logic [15:0] l;
      l = 16'h0001;
      for (int i = 0; i < 64; i++) begin
         b[i] = l[0];
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      return b;
   endfunction

   task automatic read_board(output logic [63:0] b);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         rd_x = 3'(i % W);
         rd_y = 3'(i / W);
         #1;
         b[i] = rd_cell;
      end
   endtask

   task automatic compare_out(input string tag);
      logic [63:0] b;
      read_board(b);
      check({tag, "_board"}, b, q_board.pop_front());
      check({tag, "_pop"}, 64'(population), 64'(q_pop.pop_front()));
      check({tag, "_gen"}, 64'(generation), 64'(q_gen.pop_front()));
   endtask

   task automatic push_expect(input logic [63:0] exp_b);
      model = exp_b;
      gen_m = gen_m + 16'd1;
      q_board.push_back(exp_b);
      q_pop.push_back(popcnt(exp_b));
      q_gen.push_back(gen_m);
   endtask

   task automatic load_board(input logic [63:0] b);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_x    = 3'(i % W);
         wr_y    = 3'(i / W);
         wr_data = b[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
      model = b;
      check("load_pop", 64'(population), 64'(popcnt(b)));
   endtask

   // Raise frame_sync (engine already waiting) and count cycles until IDLE.
   task automatic pulse_wait(input bit poke, output int cyc);
      frame_sync = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 3) frame_sync = 1'b0;
         if (poke) begin
            if (cyc >= 10 && cyc < 40) begin
               wr_en   = 1'b1;
               wr_x    = 3'(cyc % W);
               wr_y    = 3'd5;
               wr_data = 1'b1;
            end else begin
               wr_en = 1'b0;
            end
         end
      end while (busy && cyc < 2000);
      frame_sync = 1'b0;
      wr_en = 1'b0;
      check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic do_step(input string tag, input logic [63:0] exp_b, input bit poke);
      int cyc;
      push_expect(exp_b);
      @(negedge clk);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      @(negedge clk);
      pulse_wait(poke, cyc);
      check({tag, "_latency"}, 64'(cyc), 64'd67);
      compare_out(tag);
   endtask

   task automatic check_init(input string tag);
      int cyc;
      logic [63:0] b;
      cyc = 0;
      while (busy && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'd64);
      read_board(b);
      check({tag, "_board"}, b, lfsr_board());
      check({tag, "_pop"}, 64'(population), 64'(popcnt(lfsr_board())));
      check({tag, "_gen"}, 64'(generation), 64'd0);
   endtask

   initial begin
      int cyc;
      logic [63:0] b;
      gen_m = '0;
      model = '0;

      // Reset and power-up INIT
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_gen", 64'(generation), 64'd0);
      check("rst_pop", 64'(population), 64'd0);
      rst_n = 1'b1;
      check_init("init");

      // Blinker, B3/S23, dead edges
      birth_mask   = 9'h008;
      survive_mask = 9'h00C;
      wrap_en      = 1'b0;
      load_board(BLINK_V);
      do_step("blink1", BLINK_H, 1'b0);
      do_step("blink2", BLINK_V, 1'b0);

      // Corner births through the torus only
      birth_mask   = 9'h008;
      survive_mask = 9'h000;
      wrap_en      = 1'b1;
      load_board(CORNERS);
      do_step("wrap_on", 64'h8000_0000_0000_0000, 1'b0);
      wrap_en = 1'b0;
      load_board(CORNERS);
      do_step("wrap_off", 64'h0, 1'b0);

      // Glider on the torus returns home after 32 generations
      birth_mask   = 9'h008;
      survive_mask = 9'h00C;
      wrap_en      = 1'b1;
      load_board(GLIDER);
      for (int s = 0; s < 32; s++) begin
         do_step("glider", life_next(model, birth_mask, survive_mask, wrap_en), 1'b0);
         check("glider_pop5", 64'(population), 64'd5);
      end
      read_board(b);
      check("glider_period", b, GLIDER);

      // Auto-run: one generation per frame_sync edge after timer expiry
      run = 1'b1;
      for (int f = 0; f < 3; f++) begin
         push_expect(life_next(model, birth_mask, survive_mask, wrap_en));
         repeat (200) @(negedge clk);
         pulse_wait(1'b0, cyc);
         check("run_latency", 64'(cyc), 64'd67);
         compare_out("run");
      end

      // Randomize at the trigger reruns INIT and clears generation
      randomize_req = 1'b1;
      repeat (200) @(negedge clk);
      pulse_wait(1'b0, cyc);
      check("rand_latency", 64'(cyc), 64'd66);
      check("rand_gen", 64'(generation), 64'd0);
      run = 1'b0;
      randomize_req = 1'b0;
      gen_m = '0;

      // Host writes during UPDATE must not disturb the pass
      wrap_en = 1'b0;
      load_board(BLINK_V);
      do_step("wr_in_update", BLINK_H, 1'b1);

      // Reset in the middle of UPDATE
      @(negedge clk);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      frame_sync = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      frame_sync = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 64'(busy), 64'd1);
      check("mid_rst_gen", 64'(generation), 64'd0);
      check("mid_rst_pop", 64'(population), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_init("reinit");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
